// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } rx_state_e;

   // Prescaler divide ratio, rounded to nearest: round(clk_hz / (baud * ovs)).
   function automatic int calc_div(input longint clk_hz, input longint baud, input longint ovs);
      longint den;
      den = baud * ovs;
      return int'((clk_hz + den / 2) / den);
   endfunction

   // 2-of-3 majority used for the mid-bit vote.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_stream_if.sv
// Received-byte stream between the UART receiver and its consumer.
//
// Handshake: the master raises m_tvalid when m_tdata holds a byte and keeps
// m_tdata/m_tvalid stable until the slave has m_tready high on a rising clock
// edge; a byte transfers on every edge where m_tvalid & m_tready are both 1.
// m_tready may be driven independently of m_tvalid.
interface uart_rx_stream_if;
   import uart_pkg::*;

   logic [BYTE_W-1:0] m_tdata;
   logic              m_tvalid;
   logic              m_tready;

   modport master (output m_tdata, output m_tvalid, input m_tready);
   modport slave  (input m_tdata, input m_tvalid, output m_tready);

endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO. Head entry is always visible on
// o_data while non-empty; push and pop may coincide at any level, and a pop
// at full frees the slot for a same-cycle push.
module uart_rx_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
      $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             w_push;
   logic             w_pop;

   assign o_empty = (r_level == '0);
   assign o_full  = (r_level == LW'(DEPTH));
   assign o_level = r_level;
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);
   // Output forced to zero while empty so nothing stale leaks downstream.
   assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver: oversampled start/data/stop recovery with 3-sample
// majority voting, byte FIFO, valid/ready output stream and error pulses.
module uart_rx_stream
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 80_000_000,
   parameter int BAUD       = 115_200,
   parameter int OVS        = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        arst_n,
   input  logic                        uart_rx,
   uart_rx_stream_if.master            m_stream,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        frame_err,
   output logic                        overrun_err,
   output rx_state_e                   dbg_state
);

   localparam int DIV = calc_div(CLK_HZ, BAUD, OVS);
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int OW  = $clog2(OVS);

   if (DIV < 2) begin : g_div_chk
      $error("uart_rx_stream: clock too slow for BAUD*OVS (DIV < 2)");
   end
   if (OVS < 8 || (OVS % 2) != 0) begin : g_ovs_chk
      $error("uart_rx_stream: OVS must be even and at least 8");
   end

   logic [1:0]        r_rst_sync;
   logic              w_rst_n;
   logic [1:0]        r_rx_sync;
   logic              w_rx_s;
   logic [PW-1:0]     r_presc;
   logic              w_tick;
   logic [1:0]        r_smp;
   logic              w_vote;
   rx_state_e         r_state;
   logic [OW-1:0]     r_ovs_cnt;
   logic [2:0]        r_bit_cnt;
   logic [BYTE_W-1:0] r_shreg;
   logic              r_push;
   logic [BYTE_W-1:0] r_push_data;
   logic              r_frame_err;
   logic              r_overrun_err;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic              w_pop;
   logic [BYTE_W-1:0] w_fifo_data;

   // Reset asserts immediately, releases two clocks after arst_n rises.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) r_rst_sync <= '0;
      else         r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   // Two-flop synchronizer for the asynchronous line, idles high.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) r_rx_sync <= 2'b11;
      else          r_rx_sync <= {r_rx_sync[0], uart_rx};
   end
   assign w_rx_s = r_rx_sync[1];

   // Free-running oversample prescaler; tick on the DIV-1 -> 0 wrap.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n)    r_presc <= '0;
      else if (w_tick) r_presc <= '0;
      else             r_presc <= r_presc + PW'(1);
   end
   assign w_tick = (r_presc == PW'(DIV - 1));

   // Two previous tick samples; with the current sample they form the vote.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n)    r_smp <= 2'b11;
      else if (w_tick) r_smp <= {r_smp[0], w_rx_s};
   end
   assign w_vote = maj3(r_smp[1], r_smp[0], w_rx_s);

   // A pop in the vote cycle frees a slot before the registered push lands.
   assign w_pop = ~w_fifo_empty & m_stream.m_tready;

   // Frame FSM: counters, shift register, push request and error pulses.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state       <= IDLE;
         r_ovs_cnt     <= '0;
         r_bit_cnt     <= '0;
         r_shreg       <= '0;
         r_push        <= 1'b0;
         r_push_data   <= '0;
         r_frame_err   <= 1'b0;
         r_overrun_err <= 1'b0;
      end else begin
         r_push        <= 1'b0;
         r_frame_err   <= 1'b0;
         r_overrun_err <= 1'b0;
         if (w_tick) begin
            case (r_state)
               IDLE: begin
                  if (!w_rx_s) begin
                     r_state   <= START;
                     r_ovs_cnt <= '0;
                  end
               end
               START: begin
                  if (r_ovs_cnt == OW'(OVS / 2 - 1)) begin
                     r_ovs_cnt <= '0;
                     r_bit_cnt <= '0;
                     r_state   <= w_vote ? IDLE : DATA;
                  end else begin
                     r_ovs_cnt <= r_ovs_cnt + OW'(1);
                  end
               end
               DATA: begin
                  if (r_ovs_cnt == OW'(OVS - 1)) begin
                     r_ovs_cnt <= '0;
                     r_shreg   <= {w_vote, r_shreg[BYTE_W-1:1]};
                     if (r_bit_cnt == 3'd7) r_state <= STOP;
                     else                   r_bit_cnt <= r_bit_cnt + 3'd1;
                  end else begin
                     r_ovs_cnt <= r_ovs_cnt + OW'(1);
                  end
               end
               STOP: begin
                  if (r_ovs_cnt == OW'(OVS - 1)) begin
                     r_ovs_cnt <= '0;
                     if (!w_vote) begin
                        r_frame_err <= 1'b1;
                        r_state     <= WAIT_IDLE;
                     end else begin
                        if (w_fifo_full && !w_pop) begin
                           r_overrun_err <= 1'b1;
                        end else begin
                           r_push      <= 1'b1;
                           r_push_data <= r_shreg;
                        end
                        r_state <= IDLE;
                     end
                  end else begin
                     r_ovs_cnt <= r_ovs_cnt + OW'(1);
                  end
               end
               WAIT_IDLE: begin
                  if (w_rx_s) r_state <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (BYTE_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (w_rst_n),
      .i_push  (r_push),
      .i_data  (r_push_data),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_level (fifo_level)
   );

   assign m_stream.m_tdata  = w_fifo_data;
   assign m_stream.m_tvalid = ~w_fifo_empty;
   assign frame_err         = r_frame_err;
   assign overrun_err       = r_overrun_err;
   assign dbg_state         = r_state;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream. Clock scaled so one bit = 64 clocks
// (DIV = 4, OVS = 16); the line model works in the same time units.
module tb_uart_rx_stream;
   import uart_pkg::*;

   localparam int CLK_HZ     = 7_372_800;
   localparam int BAUD       = 115_200;
   localparam int OVS        = 16;
   localparam int FIFO_DEPTH = 16;
   localparam int BIT_T      = 640;   // 64 clocks of period 10
   localparam int BIT_SLOW   = 659;   // +3 %
   localparam int BIT_FAST   = 621;   // -3 %

   logic       clk = 1'b0;
   logic       arst_n = 1'b0;
   logic       uart_rx = 1'b1;
   logic [4:0] fifo_level;
   logic       frame_err;
   logic       overrun_err;
   rx_state_e  dbg_state;

   uart_rx_stream_if s_if ();

   uart_rx_stream #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .OVS        (OVS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .uart_rx     (uart_rx),
      .m_stream    (s_if),
      .fifo_level  (fifo_level),
      .frame_err   (frame_err),
      .overrun_err (overrun_err),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   logic [7:0] exp_q[$];
   logic [7:0] rcv_q[$];
   int checks   = 0;
   int failures = 0;
   int fe_cnt   = 0;
   int ov_cnt   = 0;
   int wide_cnt = 0;
   int both_cnt = 0;
   logic prev_fe = 1'b0;
   logic prev_ov = 1'b0;

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (s_if.m_tvalid && s_if.m_tready) rcv_q.push_back(s_if.m_tdata);
      if (frame_err) fe_cnt++;
      if (overrun_err) ov_cnt++;
      if ((frame_err && prev_fe) || (overrun_err && prev_ov)) wide_cnt++;
      if (frame_err && overrun_err) both_cnt++;
      prev_fe = frame_err;
      prev_ov = overrun_err;
   end

   // ---------------- driver / check tasks ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drives one 8N1 frame; the line is left at the stop-bit level.
   task automatic send_byte(input logic [7:0] b, input int bit_t, input logic stop_val);
      uart_rx = 1'b0;
      #(bit_t);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         #(bit_t);
      end
      uart_rx = stop_val;
      #(bit_t);
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk);
      #1 s_if.m_tready = v;
      @(negedge clk);
   endtask

   task automatic check_stream(input string tag);
      logic [7:0] e;
      logic [7:0] g;
      check({tag, "_count"}, rcv_q.size(), exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (rcv_q.size() > 0) ? rcv_q.pop_front() : 8'hxx;
         check({tag, "_byte"}, g, e);
      end
      rcv_q.delete();
   endtask

   // ---------------- directed sequence ----------------
   logic [7:0] msg [12];
   int fe0;
   int ov0;
   int n;

   initial begin
      msg = '{8'h46, 8'h50, 8'h47, 8'h41, 8'h20, 8'h72,
              8'h61, 8'h6A, 8'h61, 8'h0D, 8'h0A, 8'h00};
      s_if.m_tready = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_tvalid", s_if.m_tvalid, 1'b0);
      check("rst_tdata", s_if.m_tdata, 8'h00);
      check("rst_level", fifo_level, 5'd0);
      check("rst_frame_err", frame_err, 1'b0);
      check("rst_overrun_err", overrun_err, 1'b0);
      check("rst_state", dbg_state, IDLE);
      @(posedge clk);
      #1 arst_n = 1'b1;
      repeat (20) @(negedge clk);

      // Message stream with m_tready=1, first byte also checks latency
      set_ready(1'b1);
      for (int i = 0; i < 12; i++) exp_q.push_back(msg[i]);
      fork
         send_byte(msg[0], BIT_T, 1'b1);
         begin
            n = 0;
            while (dbg_state != STOP && n < 2000) begin @(negedge clk); n++; end
            n = 0;
            while (dbg_state == STOP && n < 200) begin @(negedge clk); n++; end
            check("lat_state_idle", dbg_state, IDLE);
            check("lat_tvalid_1clk", s_if.m_tvalid, 1'b0);
            @(negedge clk);
            check("lat_tvalid_2clk", s_if.m_tvalid, 1'b1);
            check("lat_tdata", s_if.m_tdata, 8'h46);
         end
      join
      #(BIT_T);
      for (int i = 1; i < 12; i++) begin
         send_byte(msg[i], BIT_T, 1'b1);
         #(BIT_T);
      end
      #(3 * BIT_T);
      check_stream("msg");
      check("msg_frame_err", fe_cnt, 0);
      check("msg_overrun_err", ov_cnt, 0);

      // Short low glitch on an idle line
      @(negedge clk);
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      uart_rx = 1'b0;
      #120;
      check("glitch_in_start", dbg_state, START);
      #30 uart_rx = 1'b1;
      #490;
      check("glitch_back_idle", dbg_state, IDLE);
      check("glitch_no_byte", rcv_q.size(), 0);
      check("glitch_tvalid", s_if.m_tvalid, 1'b0);
      check("glitch_frame_err", fe_cnt, fe0);
      check("glitch_overrun_err", ov_cnt, ov0);

      // Bad stop bit followed by a held-low line, then a good byte
      #(2 * BIT_T);
      @(negedge clk);
      send_byte(8'h55, BIT_T, 1'b0);
      #2000;
      check("break_wait_idle", dbg_state, WAIT_IDLE);
      #2000;
      uart_rx = 1'b1;
      #(2 * BIT_T);
      exp_q.push_back(8'hA3);
      send_byte(8'hA3, BIT_T, 1'b1);
      #(2 * BIT_T);
      check("break_frame_err", fe_cnt, fe0 + 1);
      check("break_overrun_err", ov_cnt, ov0);
      check_stream("break");

      // FIFO fill and overrun with m_tready=0
      set_ready(1'b0);
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back(8'(i));
         send_byte(8'(i), BIT_T, 1'b1);
         #(BIT_T);
      end
      check("fill_level16", fifo_level, 5'd16);
      check("fill_tvalid", s_if.m_tvalid, 1'b1);
      check("fill_head", s_if.m_tdata, 8'h00);
      check("fill_no_overrun", ov_cnt, ov0);
      send_byte(8'h10, BIT_T, 1'b1);
      #(BIT_T);
      check("ovr_pulse", ov_cnt, ov0 + 1);
      check("ovr_level", fifo_level, 5'd16);
      check("ovr_head_held", s_if.m_tdata, 8'h00);
      check("ovr_frame_err", fe_cnt, fe0);
      set_ready(1'b1);
      n = 0;
      while (s_if.m_tvalid && n < 100) begin @(negedge clk); n++; end
      check("drain_tvalid", s_if.m_tvalid, 1'b0);
      check("drain_level", fifo_level, 5'd0);
      check_stream("drain");

      // Bit-time tolerance, frames back to back
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      for (int r = 0; r < 2; r++) begin
         exp_q.push_back(8'h00);
         exp_q.push_back(8'hFF);
         exp_q.push_back(8'h5A);
         send_byte(8'h00, (r == 0) ? BIT_FAST : BIT_SLOW, 1'b1);
         send_byte(8'hFF, (r == 0) ? BIT_FAST : BIT_SLOW, 1'b1);
         send_byte(8'h5A, (r == 0) ? BIT_FAST : BIT_SLOW, 1'b1);
         #(2 * BIT_T);
      end
      check_stream("tol");
      check("tol_frame_err", fe_cnt, fe0);
      check("tol_overrun_err", ov_cnt, ov0);

      // Reset in the middle of a frame, with one byte buffered
      set_ready(1'b0);
      send_byte(8'h77, BIT_T, 1'b1);
      #(BIT_T);
      check("prerst_level", fifo_level, 5'd1);
      @(negedge clk);
      fork
         send_byte(8'h3C, BIT_T, 1'b1);
         begin
            #(5 * BIT_T + BIT_T / 2);
            arst_n = 1'b0;
            #20;
            check("midrst_tvalid", s_if.m_tvalid, 1'b0);
            check("midrst_tdata", s_if.m_tdata, 8'h00);
            check("midrst_level", fifo_level, 5'd0);
            check("midrst_frame_err", frame_err, 1'b0);
            check("midrst_overrun_err", overrun_err, 1'b0);
            check("midrst_state", dbg_state, IDLE);
            #(5 * BIT_T);
            arst_n = 1'b1;
         end
      join
      rcv_q.delete();
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      set_ready(1'b1);
      #(2 * BIT_T);
      check("postrst_tvalid", s_if.m_tvalid, 1'b0);
      exp_q.push_back(8'hC3);
      send_byte(8'hC3, BIT_T, 1'b1);
      #(2 * BIT_T);
      check_stream("postrst");
      check("postrst_frame_err", fe_cnt, fe0);
      check("postrst_overrun_err", ov_cnt, ov0);

      // Pulse shape over the whole run
      check("pulse_width_1clk", wide_cnt, 0);
      check("pulse_exclusive", both_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_stream.md
Name: uart_rx_stream

Overview:
- Synthesizable 8N1 UART receiver: the DUT-side consumer of the serial line driven by the team's UART bus-functional model.
- Oversamples the asynchronous rx pin and recovers bytes.
- Buffers bytes in a small FIFO and presents them on a valid/ready byte stream to the downstream command parser / CSR bridge.
- Reports framing and overrun errors as single-cycle pulses.

Parameters:
- CLK_HZ, 80_000_000, system clock frequency in Hz.
- BAUD, 115_200, line rate in bit/s (one bit = 8.68 us).
- OVS, 16, oversampling ticks per bit; must be ≥ 8 and even.
- FIFO_DEPTH, 16, byte FIFO entries; power of two, ≥ 2.

Ports:
- clk, in, 1, system clock.
- arst_n, in, 1, asynchronous active-low reset.
- uart_rx, in, 1, asynchronous serial input; idle-high.
- m_tdata, out, 8, received byte at FIFO head.
- m_tvalid, out, 1, FIFO non-empty.
- m_tready, in, 1, consumer accepts the byte when m_tvalid & m_tready.
- fifo_level, out, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.
- frame_err, out, 1, one-cycle pulse: stop bit sampled 0.
- overrun_err, out, 1, one-cycle pulse: byte completed while FIFO full.

Behaviour:
- Reset (async assert, sync release through the codebase's reset style):
  - FSM = IDLE, FIFO empty, m_tvalid=0, m_tdata=0, fifo_level=0, frame_err=0, overrun_err=0.
  - Synchronizer flops preset to 1; prescaler = 0.
- Input synchronizer: 2-FF, reset to 1. All logic uses the synchronized value rx_s.
- Tick generator:
  - Free-running counter, DIV = round(CLK_HZ/(BAUD*OVS)), 43 at defaults; emits a 1-cycle tick when the count wraps DIV-1 → 0.
  - Static assertion: DIV ≥ 2.
- FSM, advanced only on ticks; ovs_cnt counts 0..OVS-1, bit_cnt counts 0..7:
  - IDLE: rx_s==0 on a tick → START, ovs_cnt=0.
  - START: at ovs_cnt==OVS/2-1, majority of 3 samples (ticks OVS/2-2..OVS/2) == 0 → DATA, counters cleared. Otherwise false start → IDLE, no pulse.
  - DATA: at mid-bit (same majority window), shift the voted bit into shreg LSB-first. After bit 7 → STOP.
  - STOP, at mid-stop-bit vote:
    - Vote 1, FIFO not full → push shreg, go to IDLE.
    - Vote 1, FIFO full → drop byte, pulse overrun_err, go to IDLE.
    - Vote 0 → pulse frame_err, drop byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1 on a tick (break/stuck-low absorbed, single frame_err per break) → IDLE.
- Latency: byte visible on m_tvalid 2 clk after the stop-bit vote tick (1 push register + FIFO read register).
- FIFO (first-word-fall-through):
  - Simultaneous push & pop is allowed at any level, including full: pop frees the slot the same cycle, so no overrun when full & m_tready & m_tvalid.
  - Pointers wrap modulo FIFO_DEPTH; fifo_level saturates logically at FIFO_DEPTH.
  - m_tdata is held stable while m_tvalid & !m_tready.
- Error pulses are exactly 1 clk and mutually exclusive per frame.
- Reset mid-frame: partial byte discarded, no pulse on release; the next valid start bit is received normally.
- Baud tolerance: receiver must decode correctly with transmitter bit-time error of up to ±3%.

Decomposition:
- Package uart_pkg:
  - rx_state_e enum {IDLE, START, DATA, STOP, WAIT_IDLE};
  - function calc_div(clk_hz, baud, ovs);
  - localparam BYTE_W=8.
- One sub-module: uart_rx_fifo, a parameterized synchronous FWFT FIFO (DEPTH, WIDTH) with push/pop/full/empty/level. Reusable by the future TX path.

Test Plan:
- BFM sends "FPGA raja\r\n" plus terminator, m_tready=1 → stream 46 50 47 41 20 72 61 6A 61 0D 0A 00 in order; frame_err=overrun_err=0.
- 2 us low glitch on idle line → no byte, no error pulse, FSM back in IDLE within 1 bit time.
- Frame 0x55 with stop bit forced 0, line then held low 50 us, then byte 0xA3 → exactly one frame_err pulse; only 0xA3 delivered.
- m_tready=0, 17 bytes 0x00..0x10 → fifo_level=16, one overrun_err on byte 0x10; release m_tready → 0x00..0x0F delivered, then m_tvalid=0.
- Bit time 8.42 us (-3%) and 8.94 us (+3%), bytes 0x00, 0xFF, 0x5A → all received correctly.
- arst_n pulsed low during bit 4 of 0x3C, then byte 0xC3 → only 0xC3 delivered; no error pulses; all outputs 0 during reset.
